fft_frame_sink: RTL

FFT_FRAME_SINK -- requirements
Module: fft_frame_sink

---
 rtl/fft_frame_sink.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fft_frame_sink.sv
// fft_frame_sink: ping-pong frame buffer between an FFT bin stream and a ready/valid consumer (define FFT_FRAME_SINK_ERRCNT_EN to add o_errcnt)
module fft_frame_sink #(
  parameter int OWIDTH = 19,
  parameter int LGSIZE = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ce,
  input  logic [2*OWIDTH-1:0]   i_sample,
  input  logic                  i_sync,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*OWIDTH-1:0]   o_data,
  output logic [LGSIZE-1:0]     o_bin,
  output logic                  o_last,
`ifdef FFT_FRAME_SINK_ERRCNT_EN
  output logic [7:0]            o_errcnt,
`endif
  output logic                  o_overflow
);
  localparam logic [0:0] W_HUNT  = 1'b0;
  localparam logic [0:0] W_FILL  = 1'b1;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_DRAIN = 1'b1;
  localparam logic [LGSIZE-1:0] LAST = {LGSIZE{1'b1}};
  localparam logic [LGSIZE-1:0] ONE  = LGSIZE'(1);

  logic [2*OWIDTH-1:0] mem [0:(2<<LGSIZE)-1];
  logic                run_q;
  logic [1:0]          full_q, full_d;
  logic [0:0]          wst_q, wst_d, rd_st_q, rd_st_d;
  logic                wb_q, wb_d, drop_q, drop_d, ovf_q, ovf_d;
  logic [LGSIZE-1:0]   widx_q, widx_d, widx_w;
  logic                rb_q, rb_d, valid_q, valid_d, last_q, last_d;
  logic [LGSIZE-1:0]   ridx_q, ridx_d, bin_q, bin_d;
  logic [2*OWIDTH-1:0] data_q;
  logic                start, adv, done, we, fetch, rd_free, wr_busy, drop_new;

  // A frame start is a qualified sync anywhere except on the last index (which completes the
  // current frame), or any sample at index 0 after a frame closed with sync on its last bin.
  assign start    = i_ce && (i_sync ? (wst_q == W_HUNT || widx_q != LAST) : (wst_q == W_FILL && widx_q == '0));
  assign adv      = !start && i_ce && wst_q == W_FILL;
  assign done     = adv && widx_q == LAST;
  assign fetch    = run_q && (!valid_q || i_ready) && full_q[rb_q] && (rd_st_q == R_DRAIN || valid_q);
  // A bank is released once its last bin has moved into the output register; this same-cycle
  // release lets a new frame claim the bank on that edge, so full-rate input never overflows.
  assign rd_free  = fetch && ridx_q == LAST;
  assign wr_busy  = full_q[wb_q] && !(rd_free && rb_q == wb_q);
  assign drop_new = start && wr_busy;
  assign we       = run_q && (start ? !wr_busy : adv && !drop_q);
  assign widx_w   = start ? {LGSIZE{1'b0}} : widx_q;

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_bin      = bin_q;
  assign o_last     = last_q;
  assign o_overflow = ovf_q;

  // Write side: hunt for sync, fill the write bank, drop whole frames when the bank is still held
  always_comb begin
    wst_d  = wst_q;
    widx_d = widx_q;
    wb_d   = wb_q;
    drop_d = drop_q;
    ovf_d  = ovf_q | drop_new;
    if (start) begin
      wst_d  = W_FILL;
      widx_d = ONE;
      drop_d = wr_busy;
    end else if (adv) begin
      widx_d = widx_q + ONE;
      wst_d  = done ? (i_sync ? W_FILL : W_HUNT) : wst_q;
      wb_d   = done && !drop_q ? ~wb_q : wb_q;
    end
  end

  // Bank flags: release on last-bin fetch, claim on frame completion
  always_comb begin
    full_d = full_q;
    if (rd_free) full_d[rb_q] = 1'b0;
    if (done && !drop_q) full_d[wb_q] = 1'b1;
  end

  // Read side: one idle cycle before the first fetch of a frame, then fetch on every free output slot
  always_comb begin
    rd_st_d = fetch ? (ridx_q == LAST ? R_IDLE : R_DRAIN) : (full_q[rb_q] ? R_DRAIN : rd_st_q);
    ridx_d  = fetch ? ridx_q + ONE : ridx_q;
    rb_d    = rd_free ? ~rb_q : rb_q;
    valid_d = fetch ? 1'b1 : (i_ready ? 1'b0 : valid_q);
    bin_d   = fetch ? ridx_q : bin_q;
    last_d  = fetch ? ridx_q == LAST : last_q;
  end

  // Release synchroniser: the first edge after deassertion only arms run_q
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) run_q <= 1'b0;
    else            run_q <= 1'b1;

  // Control state registers
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      wst_q   <= W_HUNT;
      widx_q  <= '0;
      wb_q    <= 1'b0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      full_q  <= '0;
      rd_st_q <= R_IDLE;
      ridx_q  <= '0;
      rb_q    <= 1'b0;
      valid_q <= 1'b0;
      bin_q   <= '0;
      last_q  <= 1'b0;
    end else if (run_q) begin
      wst_q   <= wst_d;
      widx_q  <= widx_d;
      wb_q    <= wb_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      full_q  <= full_d;
      rd_st_q <= rd_st_d;
      ridx_q  <= ridx_d;
      rb_q    <= rb_d;
      valid_q <= valid_d;
      bin_q   <= bin_d;
      last_q  <= last_d;
    end

  // Sample storage and output data register (contents are don't-care after reset)
  always_ff @(posedge i_clk) begin
    if (we) mem[{wb_q, widx_w}] <= i_sample;
    if (fetch) data_q <= mem[{rb_q, ridx_q}];
  end

`ifdef FFT_FRAME_SINK_ERRCNT_EN
  logic       abandon;
  logic [7:0] errcnt_q;
  assign abandon  = start && wst_q == W_FILL && widx_q != '0 && !drop_q;
  assign o_errcnt = errcnt_q;

  // Saturating count of dropped and abandoned frames
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) errcnt_q <= '0;
    else if (run_q && (drop_new || abandon) && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
`endif
endmodule
